// File: rtl/uart_pkg.sv
// Shared state type, oversampling constants and vote helper for the UART receiver.
// UART_RX_PARITY_EN enables the PARITY state in the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID_TICK   = 8;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through byte buffer.
// Head reads as zero while the buffer is empty.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push)
                     - (AW+1)'(pop);
    end
  end

  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_rx_oversample.sv
// 16x oversampling UART receiver with majority vote and byte FIFO.
// Define UART_RX_PARITY_EN for an even-parity bit and PARITY_ERR pulse.
module uart_rx_oversample #(
  parameter int TICK_DIV   = 54,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 RX_IN,
  output logic [DATA_BITS-1:0] RX_DOUT,
  output logic                 RX_VALID,
  input  logic                 RX_READY,
  output logic                 RX_DONE,
  output logic                 FRAME_ERR,
`ifdef UART_RX_PARITY_EN
  output logic                 PARITY_ERR,
`endif
  output logic                 OVERRUN
);

  import uart_pkg::*;

  localparam int DW = $clog2(TICK_DIV);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ?
                      $clog2(DATA_BITS) : 1;

  localparam logic [DW-1:0] DIV_LAST =
    DW'(TICK_DIV - 1);
  localparam logic [TW-1:0] T_LAST =
    TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] T_S0 =
    TW'(MID_TICK - 1);
  localparam logic [TW-1:0] T_S1 =
    TW'(MID_TICK);
  localparam logic [TW-1:0] T_S2 =
    TW'(MID_TICK + 1);
  localparam logic [BW-1:0] B_LAST =
    BW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  localparam rx_state_t AFTER_DATA = PARITY;
  logic par_bad;
`else
  localparam rx_state_t AFTER_DATA = STOP;
`endif

  rx_state_t state, state_n;

  logic rx_m, rx_s, rx_p;
  logic [DW-1:0] div_cnt;
  logic [TW-1:0] tick_cnt, tick_nxt;
  logic [BW-1:0] bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic s0, s1;
  logic tick, start_edge, vote;
  logic at_vote, at_end, stop_vote;
  logic push_req, keep, push, pop;
  logic full, empty;

  // tick_nxt is the tick number within the bit once this tick lands
  assign tick       = div_cnt == DIV_LAST;
  assign tick_nxt   = tick_cnt + 1'b1;
  assign at_vote    = tick && tick_nxt == T_S2;
  assign at_end     = tick && tick_cnt == T_LAST;
  assign vote       = maj3(s0, s1, rx_s);
  assign start_edge = state == IDLE &&
                      rx_p && !rx_s;
  assign stop_vote  = state == STOP && at_vote;

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (start_edge) state_n = START;
      START:
        if (at_vote && vote) state_n = IDLE;
        else if (at_end)     state_n = DATA;
      DATA:
        if (at_end && bit_cnt == B_LAST)
          state_n = AFTER_DATA;
`ifdef UART_RX_PARITY_EN
      PARITY:
        if (at_end) state_n = STOP;
`endif
      STOP:
        if (at_vote) state_n = vote ? IDLE : BREAK;
      BREAK:
        if (rx_s) state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rx_m     <= 1'b1;
      rx_s     <= 1'b1;
      rx_p     <= 1'b1;
      div_cnt  <= '0;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      s0       <= 1'b1;
      s1       <= 1'b1;
    end else begin
      rx_m <= RX_IN;
      rx_s <= rx_m;
      rx_p <= rx_s;
      if (start_edge || tick) div_cnt <= '0;
      else div_cnt <= div_cnt + 1'b1;
      if (start_edge) tick_cnt <= '0;
      else if (tick)  tick_cnt <= tick_nxt;
      if (tick && tick_nxt == T_S0) s0 <= rx_s;
      if (tick && tick_nxt == T_S1) s1 <= rx_s;
      if (start_edge) bit_cnt <= '0;
      else if (state == DATA && at_end)
        bit_cnt <= bit_cnt + 1'b1;
      if (state == DATA && at_vote)
        shreg <= {vote, shreg[DATA_BITS-1:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      par_bad    <= 1'b0;
      PARITY_ERR <= 1'b0;
    end else begin
      if (state == PARITY && at_vote)
        par_bad <= vote ^ (^shreg);
      PARITY_ERR <= push_req && par_bad;
    end
  end
  assign keep = push_req && !par_bad;
`else
  assign keep = push_req;
`endif

  // a pop in the push cycle frees a slot even when full
  assign pop      = !empty && RX_READY;
  assign push     = keep && (!full || pop);
  assign RX_VALID = !empty;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      push_req  <= 1'b0;
      RX_DONE   <= 1'b0;
      FRAME_ERR <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      push_req  <= stop_vote && vote;
      FRAME_ERR <= stop_vote && !vote;
      RX_DONE   <= push;
      OVERRUN   <= keep && full && !pop;
    end
  end

  uart_rx_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(DATA_BITS)
  ) u_fifo (
    .clk  (CLK),
    .rst  (RESET),
    .push (push),
    .pop  (pop),
    .din  (shreg),
    .dout (RX_DOUT),
    .full (full),
    .empty(empty)
  );

endmodule

// File: doc/uart_rx_oversample.md
Name: uart_rx_oversample

Overview:
Standalone UART receiver: the far-end counterpart to the serial TX line driven by the loopback transmitter.
- Line handling: synchronizes RX_IN, detects start bits with 16x oversampling and majority-votes each data bit.
- Frame checks: checks the stop bit, flags framing errors.
- Output buffering: buffers received bytes in a small FIFO with a valid/ready read port.
- Placement: sits between the serial pin and the byte-consumer logic.

Parameters:
TICK_DIV, 54, CLK cycles per oversample tick (100 MHz / (115200*16)); minimum 2
OVERSAMPLE, 16, ticks per bit; fixed, must be 16
DATA_BITS, 8, data bits per frame, LSB first
FIFO_DEPTH, 4, received-byte buffer entries; power of two, ≥2

Ports:
CLK  in  1  system clock, all logic rising-edge
RESET  in  1  synchronous, active-high reset
RX_IN  in  1  asynchronous serial line, idle high
RX_DOUT  out  DATA_BITS  FIFO head byte (first-word fall-through)
RX_VALID  out  1  FIFO non-empty; RX_DOUT valid
RX_READY  in  1  consumer pops head when RX_VALID & RX_READY
RX_DONE  out  1  one-cycle pulse: good frame accepted into FIFO
FRAME_ERR  out  1  one-cycle pulse: stop bit sampled low
OVERRUN  out  1  one-cycle pulse: good frame dropped, FIFO full

Behaviour:
- Reset values: RX_DOUT=0, RX_VALID=0, RX_DONE=0, FRAME_ERR=0, OVERRUN=0. The following are cleared:
  - FIFO pointers and count
  - synchronizer flops (to 1)
  - tick divider, tick/bit counters
  - FSM → IDLE
- Reset mid-frame: the partial byte is discarded; no pulses are emitted.
- Synchronizer: 2-flop on RX_IN; all logic uses the synced signal rx_s. Adds 2 cycles of latency.
- Tick generator:
  - Free-running counter 0..TICK_DIV-1; emits tick on terminal count.
  - Reloaded to 0 when IDLE detects a start edge, aligning sampling to the edge.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: on rx_s 1→0 → START, tick_cnt=0.
  - START: at tick_cnt=7, 8 and 9 sample rx_s; majority at tick 9.
    - Majority 1 (glitch) → IDLE, no pulses.
    - Majority 0 → DATA, tick_cnt=0, bit_cnt=0.
  - DATA: same 7/8/9 majority per bit; shift in LSB first. After tick 15 of bit DATA_BITS-1 → STOP.
  - STOP: majority at tick 9.
    - If 1: frame good. Next cycle, push to FIFO → IDLE.
    - If 0: FRAME_ERR pulse, byte discarded → BREAK.
  - BREAK: wait for rx_s=1 → IDLE. Handles held-low break conditions with no repeated errors.
- Push cycle (cycle after stop majority):
  - If FIFO not full, or a pop happens in the same cycle: write the byte, RX_DONE=1.
  - Otherwise: OVERRUN=1, byte dropped, FIFO unchanged.
- FIFO:
  - RX_VALID=1 the cycle after the first push into an empty FIFO.
  - Pop when RX_VALID&RX_READY; RX_DOUT updates to the next entry the following cycle.
  - Simultaneous push+pop when full: both occur, count unchanged, no OVERRUN.
  - Simultaneous push+pop when empty: impossible, since RX_VALID=0.
  - Pointers wrap modulo FIFO_DEPTH.
- Pulses: RX_DONE, FRAME_ERR and OVERRUN are registered and mutually exclusive per frame.
- Latency: line start edge → RX_DONE = 2 + (10 frames-bits worth ≈ 9.5 bits)*16*TICK_DIV + ~2 cycles; the bench checks ±TICK_DIV.

Optional Feature:
Macro: UART_RX_PARITY_EN.
- Defined: adds state PARITY between DATA and STOP.
  - Parity bit is sampled by majority; even parity is checked.
  - Mismatch produces a one-cycle PARITY_ERR output pulse at the push cycle. The byte is discarded; RX_DONE is not asserted.
  - The FSM then proceeds to STOP normally.
- Undefined: no PARITY state and no PARITY_ERR port; frames are 1+DATA_BITS+1 bits.

Decomposition:
- Package uart_pkg: state enum rx_state_t (IDLE, START, DATA, PARITY, STOP, BREAK), constants OVERSAMPLE=16, MID_TICK=8, function maj3.
- One sub-module, uart_rx_fifo: parameterized depth/width; sync FWFT FIFO with push/pop/full/empty.
- The FSM, synchronizer and tick logic stay in uart_rx_oversample.

Test Plan:
- TICK_DIV=4: send 0x55, 8N1, bit period 64 cycles.
  - Required: one RX_DONE, RX_VALID, RX_DOUT=0x55.
  - Pop with RX_READY → RX_VALID=0.
- Send 0xA3, 0xFF, 0x1C back-to-back with RX_READY=0.
  - Required: three RX_DONE; then pops return 0xA3, 0xFF, 0x1C in order.
- Send 0x00 with stop bit driven 0 for 2 bit times.
  - Required: FRAME_ERR pulse, no RX_DONE, FIFO empty.
  - Line high, then 0x3C → RX_DOUT=0x3C.
- Glitch: RX_IN low for 3 ticks only.
  - Required: no pulses, FSM back to IDLE, next frame 0x81 received correctly.
- FIFO_DEPTH=4, RX_READY=0: send 5 bytes 0x01..0x05.
  - Required: four RX_DONE, OVERRUN on the fifth; pops yield 0x01..0x04.
- Assert RESET mid-DATA of 0x99.
  - Required: all outputs 0, FIFO empty, no pulses.
  - Next frame 0x42 is received correctly.
